// File: rtl/instfetch_stage_if.sv
// Instruction-memory bus between the IF stage and imem.
// req/addr/gnt request handshake, in-order rvalid/rdata responses.
interface instfetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/instfetch_stage.sv
// IF stage: sequential fetch, prefetch FIFO, redirect and
// misaligned-target handling, feeding pc2/instr2 to decode.
module instfetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    input  logic              hold,
    instfetch_stage_if.master imem,
    output logic [31:0]       pc2,
    output logic [31:0]       instr2,
    output logic              instruction_addr_misaligned2,
    output logic              fetch_valid2
);
    localparam logic [31:0] NOP = 32'h0000_0033;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        MISAL = 2'd1,
        HALT  = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    state_t        state_q;
    state_t        state_d;
    logic [31:0]   fetch_pc_q;
    logic [31:0]   resp_pc_q;
    logic [31:0]   pc2_q;
    logic [CW-1:0] outstanding_q;
    logic [CW-1:0] discard_q;
    logic [CW-1:0] count_q;
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    fetch_entry_t  fifo_q [FIFO_DEPTH];

    logic          credit_ok;
    logic          fire;
    logic          rsp;
    logic          drop;
    logic          push;
    logic          pop;
    logic          fifo_pop;
    logic          fifo_empty;
    fetch_entry_t  head;

    // Request issue under the credit rule, response classification
    always_comb begin
        credit_ok = ({1'b0, outstanding_q} + {1'b0, count_q})
                    < DEPTH_C;
        imem.imem_req  = nrst && (state_q == FETCH)
                         && !redirect && credit_ok;
        imem.imem_addr = fetch_pc_q;
        fire = imem.imem_req && imem.imem_gnt;
        rsp  = imem.imem_rvalid && (outstanding_q != '0);
        drop = rsp && (discard_q != '0);
        push = rsp && !drop && !redirect;
    end

    // Present FIFO head, misaligned marker, or idle NOP
    always_comb begin
        fifo_empty = (count_q == '0);
        head = fifo_q[rd_ptr_q];
        pc2 = pc2_q;
        instr2 = NOP;
        instruction_addr_misaligned2 = 1'b0;
        fetch_valid2 = 1'b0;
        unique case (1'b1)
            (state_q == MISAL): begin
                pc2 = fetch_pc_q;
                instruction_addr_misaligned2 = 1'b1;
                fetch_valid2 = 1'b1;
            end
            ((state_q == FETCH) && !fifo_empty): begin
                pc2 = head.pc;
                instr2 = head.instr;
                fetch_valid2 = 1'b1;
            end
            default: begin
            end
        endcase
        pop = fetch_valid2 && !hold;
        fifo_pop = pop && (state_q == FETCH) && !fifo_empty;
    end

    // Next state: redirect wins, marker pop parks in HALT
    always_comb begin
        state_d = state_q;
        if (redirect) begin
            if (redirect_pc[1:0] == 2'b00) begin
                state_d = FETCH;
            end else begin
                state_d = MISAL;
            end
        end else if ((state_q == MISAL) && !hold) begin
            state_d = HALT;
        end
    end

    // State register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Fetch/response pointers, credits, discard and FIFO control
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else if (redirect) begin
            fetch_pc_q    <= redirect_pc;
            resp_pc_q     <= redirect_pc;
            outstanding_q <= outstanding_q - CW'(rsp);
            discard_q     <= outstanding_q - CW'(rsp);
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            if (fire) begin
                fetch_pc_q <= fetch_pc_q + 32'd4;
            end
            outstanding_q <= outstanding_q + CW'(fire)
                             - CW'(rsp);
            if (drop) begin
                discard_q <= discard_q - CW'(1);
            end
            if (push) begin
                resp_pc_q <= resp_pc_q + 32'd4;
                wr_ptr_q  <= wr_ptr_q + AW'(1);
            end
            if (fifo_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(push) - CW'(fifo_pop);
        end
    end

    // Prefetch storage, written with the pc the response belongs to
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else if (push) begin
            fifo_q[wr_ptr_q] <= '{pc: resp_pc_q,
                                   instr: imem.imem_rdata};
        end
    end

    // Remember last presented pc for idle cycles
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pc2_q <= RESET_PC;
        end else begin
            pc2_q <= pc2;
        end
    end
endmodule
